// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix coprocessor front end and its arithmetic units:
// instruction opcodes, op_select codes, loader FSM states and matrix geometry.
package matrix_pkg;

    localparam int LANE_W    = 8;
    localparam int NUM_LANES = 32;
    localparam int MAT_DIM   = 5;
    localparam int MAT_ELEMS = MAT_DIM * MAT_DIM;

    localparam logic [2:0] OPC_NOP    = 3'b000;
    localparam logic [2:0] OPC_LOAD   = 3'b001;
    localparam logic [2:0] OPC_COMMIT = 3'b010;
    localparam logic [2:0] OPC_EXEC   = 3'b011;
    localparam logic [2:0] OPC_CLEAR  = 3'b100;
    localparam logic [2:0] OPC_CLRERR = 3'b101;

    // Code 10 is an alias of sum so that every op_select value is meaningful.
    localparam logic [1:0] OPS_SUM       = 2'b00;
    localparam logic [1:0] OPS_SUB       = 2'b01;
    localparam logic [1:0] OPS_SUM_ALT   = 2'b10;
    localparam logic [1:0] OPS_TRANSPOSE = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_EXEC  = 2'd2
    } state_t;

    function automatic int unsigned elem_lane(input int unsigned row, input int unsigned col);
        return row * MAT_DIM + col;
    endfunction

endpackage

// File: rtl/matrix_loader.sv
// Host-facing loader: assembles int8 matrices in a staging buffer, commits them to the
// matrix RAM and launches coprocessor operations with a bounded wait for op_done.
module matrix_loader
    import matrix_pkg::*;
#(
    parameter int DATA_W  = 256,
    parameter int ELEM_W  = 8,
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       instr,
    input  logic              instr_valid,
    output logic              instr_ready,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    output logic [1:0]        op_select,
    output logic              start_operation,
    input  logic              op_done,
    output logic              exec_done,
    output logic              error,
    output logic [1:0]        state_dbg
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t            state_q;
    state_t            state_d;
    logic [DATA_W-1:0] buf_q;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        opsel_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              exec_done_q;
    logic              error_q;
    logic [2:0]        opcode;
    logic [4:0]        lane;
    logic              unused_instr_bits;

    assign opcode            = instr[2:0];
    assign lane              = instr[7:3];
    assign unused_instr_bits = ^instr[31:16];

    // Handshake: an instruction transfers on a rising edge where instr_valid && instr_ready;
    // instr_ready is high exactly in IDLE, so the host holds instr/instr_valid until then.
    always_comb begin
        state_d         = state_q;
        instr_ready     = 1'b0;
        ram_wren        = 1'b0;
        start_operation = 1'b0;
        case (state_q)
            ST_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    if (opcode == OPC_COMMIT) begin
                        state_d = ST_WRITE;
                    end else if (opcode == OPC_EXEC) begin
                        state_d = ST_EXEC;
                    end
                end
            end
            ST_WRITE: begin
                ram_wren = 1'b1;
                state_d  = ST_IDLE;
            end
            ST_EXEC: begin
                start_operation = 1'b1;
                if (op_done || cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_q       <= '0;
            addr_q      <= '0;
            opsel_q     <= '0;
            cnt_q       <= '0;
            exec_done_q <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            exec_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (instr_valid) begin
                        case (opcode)
                            OPC_LOAD:   buf_q[lane*ELEM_W +: ELEM_W] <= instr[8 +: ELEM_W];
                            OPC_COMMIT: addr_q <= instr[3 +: ADDR_W];
                            OPC_EXEC: begin
                                opsel_q <= instr[4:3];
                                cnt_q   <= '0;
                            end
                            OPC_CLEAR:  buf_q <= '0;
                            OPC_CLRERR: error_q <= 1'b0;
                            3'b110, 3'b111: error_q <= 1'b1;
                            default: ;
                        endcase
                    end
                end
                ST_EXEC: begin
                    // op_done has priority over the timeout on the same edge.
                    if (op_done) begin
                        exec_done_q <= 1'b1;
                    end else if (cnt_q == CNT_LAST) begin
                        error_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ram_address = addr_q;
    assign ram_data    = buf_q;
    assign op_select   = opsel_q;
    assign exec_done   = exec_done_q;
    assign error       = error_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_matrix_loader.sv
// Directed bench for matrix_loader: buffer assembly, RAM commits, EXEC completion,
// timeout, illegal opcodes, handshake stalling and asynchronous reset.
module tb_matrix_loader;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  instr;
    logic         instr_valid;
    logic         instr_ready;
    logic [7:0]   ram_address;
    logic [255:0] ram_data;
    logic         ram_wren;
    logic [1:0]   op_select;
    logic         start_operation;
    logic         op_done;
    logic         exec_done;
    logic         error;
    logic [1:0]   state_dbg;

    int n_checks = 0;
    int n_err = 0;
    int wr_cycles = 0;
    int exec_pulses = 0;
    int stall_bad = 0;
    bit watch_ready = 1'b0;

    logic [263:0] exp_q[$];
    logic [263:0] wr_exp;
    logic [255:0] exp_buf;

    always #5 clk = ~clk;

    matrix_loader dut (
        .clk             (clk),
        .rst             (rst),
        .instr           (instr),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .ram_address     (ram_address),
        .ram_data        (ram_data),
        .ram_wren        (ram_wren),
        .op_select       (op_select),
        .start_operation (start_operation),
        .op_done         (op_done),
        .exec_done       (exec_done),
        .error           (error),
        .state_dbg       (state_dbg)
    );

    task automatic check(input string tag, input logic [263:0] got, input logic [263:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every RAM write cycle must match the next expected {address, data}.
    always @(negedge clk) begin
        if (ram_wren) begin
            wr_cycles++;
            if (exp_q.size() == 0) begin
                check("ram_write_unexpected", {ram_address, ram_data}, 264'd0);
            end else begin
                wr_exp = exp_q.pop_front();
                check("ram_write", {ram_address, ram_data}, wr_exp);
            end
        end
        if (exec_done) exec_pulses++;
        if (watch_ready && !instr_ready && !ram_wren) stall_bad++;
    end

    function automatic logic [31:0] f_load(input logic [4:0] ln, input logic [7:0] val);
        return {16'h0, val, ln, 3'b001};
    endfunction

    function automatic logic [31:0] f_commit(input logic [7:0] addr);
        return {21'h0, addr, 3'b010};
    endfunction

    function automatic logic [31:0] f_exec(input logic [1:0] op);
        return {27'h0, op, 3'b011};
    endfunction

    // Drive an instruction and hold it until accepted; returns 1 time unit after the accepting edge.
    task automatic send(input logic [31:0] w);
        int waited;
        @(negedge clk);
        instr = w;
        instr_valid = 1'b1;
        waited = 0;
        while (!instr_ready && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 400) check("send_accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int wb;
        int ep;
        int hi;
        rst = 1'b0;
        instr = '0;
        instr_valid = 1'b0;
        op_done = 1'b0;
        #12;
        check("rst_ready", instr_ready, 1);
        check("rst_wren", ram_wren, 0);
        check("rst_addr", ram_address, 0);
        check("rst_data", ram_data, 0);
        check("rst_opsel", op_select, 0);
        check("rst_start", start_operation, 0);
        check("rst_exec_done", exec_done, 0);
        check("rst_error", error, 0);
        check("rst_state", state_dbg, 0);
        @(negedge clk);
        rst = 1'b1;

        // 25 LOADs lane k <- k+1, then COMMIT to address 1
        exp_buf = '0;
        for (int k = 0; k < 25; k++) begin
            send(f_load(5'(k), 8'(k + 1)));
            exp_buf[k*8 +: 8] = 8'(k + 1);
            if (k == 0) check("load_latency", ram_data, exp_buf);
        end
        check("buf_after_loads", ram_data, exp_buf);
        check("lane24", ram_data[199:192], 8'd25);
        check("pad_lanes_zero", ram_data[255:200], 0);
        wb = wr_cycles;
        exp_q.push_back({8'd1, exp_buf});
        send(f_commit(8'd1));
        check("commit_wren", ram_wren, 1);
        check("commit_ready_low", instr_ready, 0);
        check("commit_addr", ram_address, 8'd1);
        @(posedge clk);
        #1;
        check("commit_ready_back", instr_ready, 1);
        check("commit_wren_drop", ram_wren, 0);
        check("commit_one_cycle", wr_cycles - wb, 1);

        // LOAD 0x7F, COMMIT 2, CLEAR, COMMIT 3; buffer persists across COMMIT
        watch_ready = 1'b1;
        wb = wr_cycles;
        send(f_load(5'd0, 8'h7F));
        exp_buf[7:0] = 8'h7F;
        exp_q.push_back({8'd2, exp_buf});
        send(f_commit(8'd2));
        send(32'h0000_0004);
        check("clear_buf", ram_data, 0);
        exp_q.push_back({8'd3, 256'd0});
        send(f_commit(8'd3));
        @(posedge clk);
        #1;
        watch_ready = 1'b0;
        check("two_commits", wr_cycles - wb, 2);
        check("ready_low_only_in_write", stall_bad, 0);
        exp_buf = '0;

        // op_done while idle is ignored
        ep = exec_pulses;
        @(negedge clk);
        op_done = 1'b1;
        @(negedge clk);
        op_done = 1'b0;
        check("idle_op_done_ignored", exec_pulses - ep, 0);
        check("idle_start_low", start_operation, 0);

        // EXEC sub, op_done sampled 10 edges after acceptance
        ep = exec_pulses;
        send(f_exec(2'b01));
        check("exec_start", start_operation, 1);
        check("exec_opsel", op_select, 2'b01);
        check("exec_ready_low", instr_ready, 0);
        hi = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (start_operation) hi++;
            if (i == 9) op_done = 1'b1;
        end
        @(posedge clk);
        #1;
        op_done = 1'b0;
        check("exec_high_cycles", hi, 10);
        check("exec_start_drop", start_operation, 0);
        check("exec_done_pulse", exec_done, 1);
        check("exec_ready_back", instr_ready, 1);
        @(posedge clk);
        #1;
        check("exec_done_one_cycle", exec_done, 0);
        check("exec_pulse_count", exec_pulses - ep, 1);
        check("exec_no_error", error, 0);
        check("exec_opsel_hold", op_select, 2'b01);

        // EXEC transpose with no op_done: timeout
        ep = exec_pulses;
        send(f_exec(2'b11));
        hi = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (start_operation) hi++;
        end
        check("timeout_high_cycles", hi, 255);
        check("timeout_error", error, 1);
        check("timeout_no_exec_done", exec_pulses - ep, 0);
        check("timeout_opsel", op_select, 2'b11);
        send(32'h0000_0005);
        check("clrerr", error, 0);

        // illegal opcode 111 leaves buffer untouched
        send(f_load(5'd3, 8'hA5));
        exp_buf[31:24] = 8'hA5;
        send(32'h0000_FF1F);
        check("illegal_error", error, 1);
        check("illegal_buf_unchanged", ram_data, exp_buf);

        // instr_valid held during EXEC is not accepted until back in IDLE
        send(f_exec(2'b00));
        @(negedge clk);
        instr = f_load(5'd4, 8'h3C);
        instr_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("held_ready_low", instr_ready, 0);
            check("held_not_loaded", ram_data, exp_buf);
            if (i < 4) @(negedge clk);
        end
        op_done = 1'b1;
        @(posedge clk);
        #1;
        op_done = 1'b0;
        check("held_not_at_done_edge", ram_data, exp_buf);
        check("held_exec_done", exec_done, 1);
        check("held_ready_back", instr_ready, 1);
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        exp_buf[39:32] = 8'h3C;
        check("held_loaded", ram_data, exp_buf);
        check("error_sticky", error, 1);
        send(32'h0000_0005);
        check("clrerr2", error, 0);

        // asynchronous reset mid-EXEC
        send(f_exec(2'b01));
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("arst_start", start_operation, 0);
        check("arst_wren", ram_wren, 0);
        check("arst_buf", ram_data, 0);
        check("arst_ready", instr_ready, 1);
        check("arst_state", state_dbg, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_buf", ram_data, 0);
        check("post_rst_start", start_operation, 0);
        check("post_rst_opsel", op_select, 0);

        check("exp_q_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
